display_scan_5: RTL and testbench

- Time-multiplexed 5-digit 7-segment scan driver for the stop-watch display path.
- Drives the 3-bit select of the 5-to-1 digit data selector.
- Receives the selected N-bit digit back and decodes it to active-low segments.
- Asserts one active-low digit anode per slot, with dead-time blanking to suppress ghosting, and a frame-complete pulse.

---
 rtl/display_scan_5.sv | 105 ++++++++++
 tb/tb_display_scan_5.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/display_scan_5.sv
// display_scan_5: 5-digit time-multiplexed 7-segment scan driver.
// Walks sel through 0..4, decodes the returned digit to active-low segments,
// drives one active-low anode per slot after a dead-time window, and pulses
// frame_done once per full 5-digit sweep.
module display_scan_5 #(
  parameter int N     = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [4:0]   blank_mask,
  input  logic [N-1:0] digit_in,
  output logic [2:0]   sel,
  output logic [4:0]   an_n,
  output logic [6:0]   seg_n,
  output logic         frame_done
);

  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_sel;
  logic [4:0]    r_an_n;
  logic [6:0]    r_seg_n;
  logic          r_frame_done;

  logic [3:0]    w_dig;
  logic          w_slot_end;
  logic          w_past_blank;
  logic [4:0]    w_onehot;
  logic          w_masked;

  // Only the low nibble is decoded; narrow inputs are zero-extended.
  generate
    if (N >= 4) begin : g_wide
      assign w_dig = digit_in[3:0];
    end else begin : g_narrow
      assign w_dig = {{(4-N){1'b0}}, digit_in};
    end
  endgenerate

  // With no dead time the anode is lit for the whole slot; skipping the
  // compare avoids a trivially-true unsigned comparison.
  generate
    if (BLANK == 0) begin : g_noblank
      assign w_past_blank = 1'b1;
    end else begin : g_blank
      assign w_past_blank = (r_cnt >= CW'(BLANK));
    end
  endgenerate

  assign w_slot_end = (r_cnt == LAST);
  assign w_onehot   = 5'b00001 << r_sel;
  assign w_masked   = |(w_onehot & blank_mask);

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Prescaler and digit select: advance sel on the prescaler wrap, hold while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 3'd0;
    end else if (en) begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_sel <= (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Display outputs: registered from the current sel/cnt so anode and segments stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an_n       <= 5'b11111;
      r_seg_n      <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_n      <= en ? hex7(w_dig) : 7'h7F;
      r_an_n       <= (en && w_past_blank && !w_masked) ? ~w_onehot : 5'b11111;
      r_frame_done <= en && w_slot_end && (r_sel == 3'd4);
    end
  end

  assign sel        = r_sel;
  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_5.sv
// tb_display_scan_5: directed bench for display_scan_5 with DIV=8.
// Instance a uses BLANK=2 and a bench-controlled enable/mask; instance b uses
// BLANK=0 with a permanently enabled scan.
module tb_display_scan_5;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, en_b;
  logic [4:0] mask, mask_b;
  logic [3:0] digs [5];
  logic [3:0] din_a, din_b;
  logic [2:0] sel_a, sel_b;
  logic [4:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       fd_a, fd_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fd    = 0;
  int n_an2   = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  // Combinational 5-to-1 selectors feeding each instance.
  always_comb begin
    din_a = 4'h0;
    din_b = 4'h0;
    if (sel_a < 3'd5) din_a = digs[sel_a];
    if (sel_b < 3'd5) din_b = 4'(sel_b) + 4'd1;
  end

  display_scan_5 #(.N(4), .DIV(DIV), .BLANK(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .blank_mask(mask), .digit_in(din_a),
    .sel(sel_a), .an_n(an_a), .seg_n(seg_a), .frame_done(fd_a));

  display_scan_5 #(.N(4), .DIV(DIV), .BLANK(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .blank_mask(mask_b), .digit_in(din_b),
    .sel(sel_b), .an_n(an_b), .seg_n(seg_b), .frame_done(fd_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k = enabled edges since reset release; outputs after edge k reflect state k-1.
  function automatic logic [4:0] exp_an(int k, int blank, logic [4:0] m);
    int p = k - 1;
    int c = p % DIV;
    int s = (p / DIV) % 5;
    if (c >= blank && !m[s]) return ~(5'b00001 << s);
    return 5'b11111;
  endfunction

  function automatic logic [6:0] exp_seg_a(int k);
    return HEX[digs[((k - 1) / DIV) % 5]];
  endfunction

  function automatic logic [6:0] exp_seg_b(int k);
    return HEX[((k - 1) / DIV) % 5 + 1];
  endfunction

  task automatic run(input int k0, input int k1, input bit with_b);
    for (int k = k0; k <= k1; k++) begin
      tick();
      chk("sel",   32'(sel_a), 32'((k / DIV) % 5));
      chk("an_n",  32'(an_a),  32'(exp_an(k, 2, mask)));
      chk("seg_n", 32'(seg_a), 32'(exp_seg_a(k)));
      chk("frame_done", 32'(fd_a), 32'((k % (5 * DIV)) == 0));
      if (fd_a) n_fd++;
      if (!an_a[2]) n_an2++;
      if (with_b) begin
        chk("b_an_n",  32'(an_b),  32'(exp_an(k, 0, 5'b0)));
        chk("b_seg_n", 32'(seg_b), 32'(exp_seg_b(k)));
      end
    end
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] esel);
    chk({tag, "_sel"},  32'(sel_a), 32'(esel));
    chk({tag, "_an_n"}, 32'(an_a),  32'h1F);
    chk({tag, "_seg"},  32'(seg_a), 32'h7F);
    chk({tag, "_fd"},   32'(fd_a),  32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    en_b   = 1'b1;
    mask   = 5'b0;
    mask_b = 5'b0;
    digs[0] = 4'd1; digs[1] = 4'd2; digs[2] = 4'd3; digs[3] = 4'd4; digs[4] = 4'd5;

    // Reset with enable high.
    repeat (3) begin
      tick();
      chk_idle("rst", 3'd0);
      chk("rst_b_an_n", 32'(an_b), 32'h1F);
    end
    rst_n = 1'b1;

    // Two full frames; instance b checked alongside for the no-blank case.
    run(1, 80, 1'b1);
    chk("fd_count_2frames", n_fd, 2);

    // Mask digit 2 and change its value; frame period must stay 40.
    mask    = 5'b00100;
    digs[2] = 4'd8;
    n_fd    = 0;
    n_an2   = 0;
    run(81, 160, 1'b0);
    chk("fd_count_masked", n_fd, 2);
    chk("an2_never_low", n_an2, 0);

    // Freeze at slot 3, cnt 5.
    run(161, 189, 1'b0);
    en = 1'b0;
    repeat (10) begin
      tick();
      chk_idle("frz", 3'd3);
    end
    en = 1'b1;
    run(190, 230, 1'b0);

    // Reset mid-slot at sel 3, cnt 6; hold past where the frame pulse would fall.
    rst_n = 1'b0;
    repeat (12) begin
      tick();
      chk_idle("rst_mid", 3'd0);
    end
    rst_n = 1'b1;
    run(1, 40, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
